aes_key_sched_ctrl: RTL and testbench

//  Sequencer for the AES-128 key-expansion datapath (aes_key_gen). Accepts a cipher key
//  via valid/ready and drives the datapath control: en, gen_key, next_rnd, rcon.

---
 rtl/aes_pkg.sv | 19 +
 rtl/aes_rcon_gen.sv | 26 ++
 rtl/aes_key_sched_ctrl.sv | 171 +++++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, constants and the GF(2^8) doubling helper for the AES-128 key-schedule controller.
package aes_pkg;

  typedef logic [127:0] key_128;
  typedef logic [7:0]   ByteType;

  localparam ByteType RCON_INIT = 8'h01;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } ks_state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic ByteType xtime(input ByteType b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: reloads to RCON_INIT or steps by xtime once per finished round.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic    clk,
  input  logic    nrst,
  input  logic    load_i,
  input  logic    advance_i,
  output ByteType rcon_o
);

  ByteType rcon_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rcon_q <= RCON_INIT;
    end else if (load_i) begin
      rcon_q <= RCON_INIT;
    end else if (advance_i) begin
      rcon_q <= xtime(rcon_q);
    end
  end

  assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Sequencer for the aes_key_gen datapath: streams round keys 0..NUM_ROUNDS, one strobe per round.
// Optional round-key cache (for reverse-order decryption) is enabled with AES_KEY_CACHE_EN.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned PIPE_LAT   = 2,
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic         ready_o,
  input  logic         hold_i,
  input  logic         abort_i,
  output logic         kg_en_o,
  output logic         kg_gen_key_o,
  output logic         kg_next_rnd_o,
  output logic [127:0] kg_key_o,
  output logic [7:0]   kg_rcon_o,
  input  logic [127:0] kg_key_i,
  output logic         rk_valid_o,
  output logic [3:0]   rk_round_o,
  output logic [127:0] rk_o,
  output logic         done_o
`ifdef AES_KEY_CACHE_EN
  ,
  input  logic [3:0]   rk_rd_addr_i,
  output logic [127:0] rk_rd_data_o,
  output logic         cache_valid_o
`endif
);

  localparam logic [2:0] WAIT_LAST = 3'(PIPE_LAT - 1);
  localparam logic [3:0] LAST_RND  = 4'(NUM_ROUNDS - 1);

  ks_state_t  state_q;
  logic [2:0] waitCnt_q;
  logic [3:0] round_q;
  key_128     kgKey_q;
  key_128     rk_q;
  logic       rkValid_q;
  logic [3:0] rkRound_q;
  logic       done_q;

  logic expand;
  logic accept;
  logic wrap;
  logic lastRound;
  logic rconLoad;
  logic rconAdvance;

  assign expand    = (state_q == EXPAND);
  assign ready_o   = (state_q == IDLE);
  assign accept    = start_i && ready_o;
  assign lastRound = (round_q == LAST_RND);
  // A round finishes on the last wait cycle unless stalled, cancelled, or already in the done cycle.
  assign wrap      = expand && !done_q && !hold_i && !abort_i && (waitCnt_q == WAIT_LAST);

  assign rconLoad    = accept || (expand && (abort_i || done_q));
  assign rconAdvance = wrap && !lastRound;

  assign kg_en_o       = expand && !hold_i;
  assign kg_gen_key_o  = expand;
  assign kg_next_rnd_o = expand && (round_q != 4'd0);
  assign kg_key_o      = kgKey_q;
  assign rk_valid_o    = rkValid_q;
  assign rk_round_o    = rkRound_q;
  assign rk_o          = rk_q;
  assign done_o        = done_q;

  aes_rcon_gen u_rcon (
    .clk      (clk),
    .nrst     (nrst),
    .load_i   (rconLoad),
    .advance_i(rconAdvance),
    .rcon_o   (kg_rcon_o)
  );

  // Round 0 is the raw key and is presented straight from the accept; the done cycle is held
  // in EXPAND so ready_o stays low for it and the return to IDLE happens one cycle later.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      round_q   <= '0;
      kgKey_q   <= '0;
      rk_q      <= '0;
      rkValid_q <= 1'b0;
      rkRound_q <= '0;
      done_q    <= 1'b0;
    end else begin
      rkValid_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q   <= EXPAND;
            kgKey_q   <= key_i;
            rk_q      <= key_i;
            rkValid_q <= 1'b1;
            rkRound_q <= 4'd0;
            round_q   <= 4'd0;
            waitCnt_q <= '0;
          end
        end
        EXPAND: begin
          if (abort_i || done_q) begin
            state_q <= IDLE;
          end else if (!hold_i) begin
            if (waitCnt_q == WAIT_LAST) begin
              waitCnt_q <= '0;
              round_q   <= round_q + 4'd1;
              rk_q      <= kg_key_i;
              rkValid_q <= 1'b1;
              rkRound_q <= round_q + 4'd1;
              done_q    <= lastRound;
            end else begin
              waitCnt_q <= waitCnt_q + 3'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AES_KEY_CACHE_EN
  localparam int CACHE_DEPTH = int'(NUM_ROUNDS) + 1;

  key_128     cache_q [CACHE_DEPTH];
  key_128     rdData_q;
  logic       cacheValid_q;
  logic       cacheWr;
  logic [3:0] cacheIdx;
  key_128     cacheData;

  assign cacheWr   = accept || wrap;
  assign cacheIdx  = accept ? 4'd0 : (round_q + 4'd1);
  assign cacheData = accept ? key_i : kg_key_i;

  // Every key that is strobed out is also written at its round index.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < CACHE_DEPTH; i++) begin
        cache_q[i] <= '0;
      end
      rdData_q     <= '0;
      cacheValid_q <= 1'b0;
    end else begin
      if (cacheWr) begin
        cache_q[cacheIdx] <= cacheData;
      end
      if (rk_rd_addr_i <= 4'(NUM_ROUNDS)) begin
        rdData_q <= cache_q[rk_rd_addr_i];
      end else begin
        rdData_q <= '0;
      end
      if (accept || (expand && abort_i)) begin
        cacheValid_q <= 1'b0;
      end else if (wrap && lastRound) begin
        cacheValid_q <= 1'b1;
      end
    end
  end

  assign rk_rd_data_o  = rdData_q;
  assign cache_valid_o = cacheValid_q;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl with a behavioural two-stage aes_key_gen model.
// Build with AES_KEY_CACHE_EN defined to also exercise the round-key cache.
module tb_aes_key_sched_ctrl;

  localparam int PIPE_LAT   = 2;
  localparam int NUM_ROUNDS = 10;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         start_i = 1'b0;
  logic [127:0] key_i = '0;
  logic         hold_i = 1'b0;
  logic         abort_i = 1'b0;
  logic         ready_o, kg_en_o, kg_gen_key_o, kg_next_rnd_o;
  logic [127:0] kg_key_o, kg_key_i, rk_o;
  logic [7:0]   kg_rcon_o;
  logic         rk_valid_o, done_o;
  logic [3:0]   rk_round_o;
`ifdef AES_KEY_CACHE_EN
  logic [3:0]   rk_rd_addr_i = '0;
  logic [127:0] rk_rd_data_o;
  logic         cache_valid_o;
`endif

  typedef struct {
    int           round;
    logic [127:0] key;
    bit           done;
    int           stamp;
  } ExpItem;

  ExpItem       expQ[$];
  ExpItem       curItem;
  int           testsRun = 0;
  int           testsFailed = 0;
  int           cyc = 0;
  int           lastBase = 0;
  logic [7:0]   sbox [256];
  logic [127:0] expRk [0:10];
  logic [127:0] gotRk [0:10];
  logic [7:0]   rconTab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  logic [127:0] dpOutQ, dpFbQ;

  aes_key_sched_ctrl #(.PIPE_LAT(PIPE_LAT), .NUM_ROUNDS(NUM_ROUNDS)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .start_i      (start_i),
    .key_i        (key_i),
    .ready_o      (ready_o),
    .hold_i       (hold_i),
    .abort_i      (abort_i),
    .kg_en_o      (kg_en_o),
    .kg_gen_key_o (kg_gen_key_o),
    .kg_next_rnd_o(kg_next_rnd_o),
    .kg_key_o     (kg_key_o),
    .kg_rcon_o    (kg_rcon_o),
    .kg_key_i     (kg_key_i),
    .rk_valid_o   (rk_valid_o),
    .rk_round_o   (rk_round_o),
    .rk_o         (rk_o),
    .done_o       (done_o)
`ifdef AES_KEY_CACHE_EN
    ,
    .rk_rd_addr_i (rk_rd_addr_i),
    .rk_rd_data_o (rk_rd_data_o),
    .cache_valid_o(cache_valid_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [127:0] nextKey(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rw, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    rw = {w3[23:0], w3[31:24]};
    t  = {sbox[rw[31:24]], sbox[rw[23:16]], sbox[rw[15:8]], sbox[rw[7:0]]} ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Datapath stand-in: one result register plus a feedback register, giving PIPE_LAT=2 per round.
  always @(posedge clk) begin
    if (kg_en_o) begin
      dpOutQ <= nextKey(kg_next_rnd_o ? dpFbQ : kg_key_o, kg_rcon_o);
      dpFbQ  <= dpOutQ;
    end
  end
  assign kg_key_i = dpOutQ;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every strobe is matched against the head of the scoreboard, including its cycle stamp.
  always @(negedge clk) begin
    if (nrst) begin
      if (rk_valid_o) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedStrobe", 128'(rk_round_o), 128'hF);
        end else begin
          curItem = expQ.pop_front();
          checkOutput("rkRound", 128'(rk_round_o), 128'(curItem.round));
          checkOutput("rkKey", rk_o, curItem.key);
          checkOutput("doneFlag", 128'(done_o), 128'(curItem.done));
          checkOutput("strobeCycle", 128'(cyc), 128'(curItem.stamp));
          if (curItem.round < NUM_ROUNDS) begin
            checkOutput("rcon", 128'(kg_rcon_o), 128'(rconTab[curItem.round]));
            checkOutput("nextRnd", 128'(kg_next_rnd_o), 128'(curItem.round != 0));
          end
          if (rk_round_o <= 4'd10) gotRk[rk_round_o] = rk_o;
        end
      end else if (done_o) begin
        checkOutput("doneWithoutStrobe", 128'(done_o), 128'h0);
      end
    end
  end

  task automatic pushExpansion(input int base, input int lastPush, input int holdRound,
                               input int holdLen);
    ExpItem it;
    for (int r = 0; r <= lastPush; r++) begin
      it.round = r;
      it.key   = expRk[r];
      it.done  = (r == NUM_ROUNDS);
      it.stamp = base + r * PIPE_LAT + ((r >= holdRound) ? holdLen : 0);
      expQ.push_back(it);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] key, input int lastPush, input int holdRound,
                               input int holdLen);
    @(negedge clk);
    checkOutput("readyBeforeStart", 128'(ready_o), 128'h1);
    pushExpansion(cyc + 1, lastPush, holdRound, holdLen);
    start_i = 1'b1;
    key_i   = key;
    @(negedge clk);
    start_i  = 1'b0;
    lastBase = cyc;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput("drainTimeout", 128'(expQ.size()), 128'h0);
      expQ.delete();
    end
    @(negedge clk);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "Ready"}, 128'(ready_o), 128'h1);
    checkOutput({tag, "En"}, 128'(kg_en_o), 128'h0);
    checkOutput({tag, "Rcon"}, 128'(kg_rcon_o), 128'h01);
  endtask

  task automatic checkResetState(input string tag);
    checkIdle(tag);
    checkOutput({tag, "GenKey"}, 128'(kg_gen_key_o), 128'h0);
    checkOutput({tag, "NextRnd"}, 128'(kg_next_rnd_o), 128'h0);
    checkOutput({tag, "KgKey"}, kg_key_o, 128'h0);
    checkOutput({tag, "Rk"}, rk_o, 128'h0);
    checkOutput({tag, "Valid"}, 128'(rk_valid_o), 128'h0);
    checkOutput({tag, "Round"}, 128'(rk_round_o), 128'h0);
    checkOutput({tag, "Done"}, 128'(done_o), 128'h0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    expRk[0] = FIPS_KEY;
    for (int r = 1; r <= NUM_ROUNDS; r++) expRk[r] = nextKey(expRk[r-1], rconTab[r-1]);

    repeat (2) @(negedge clk);
    checkResetState("reset");
    nrst = 1'b1;

    // Plain expansion of the FIPS-197 key.
    applyStimulus(FIPS_KEY, NUM_ROUNDS, 99, 0);
    waitDrain(40);
    checkOutput("fipsRound1", gotRk[1], FIPS_R1);
    checkOutput("fipsRound10", gotRk[10], FIPS_R10);
    checkIdle("afterExpand");

`ifdef AES_KEY_CACHE_EN
    rk_rd_addr_i = 4'd10;
    @(negedge clk);
    checkOutput("cacheRd10", rk_rd_data_o, FIPS_R10);
    checkOutput("cacheValidSet", 128'(cache_valid_o), 128'h1);
    rk_rd_addr_i = 4'd11;
    @(negedge clk);
    checkOutput("cacheRd11", rk_rd_data_o, 128'h0);
    rk_rd_addr_i = 4'd0;
    @(negedge clk);
    checkOutput("cacheRd0", rk_rd_data_o, FIPS_KEY);
    applyStimulus(FIPS_KEY, NUM_ROUNDS, 99, 0);
    checkOutput("cacheValidClr", 128'(cache_valid_o), 128'h0);
    waitDrain(40);
`endif

    // Three-cycle stall while round 4 is being computed.
    applyStimulus(FIPS_KEY, NUM_ROUNDS, 4, 3);
    waitUntil(lastBase + 3 * PIPE_LAT);
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("holdEn", 128'(kg_en_o), 128'h0);
      @(negedge clk);
    end
    hold_i = 1'b0;
    waitDrain(40);
    checkIdle("afterHold");

    // Abort together with hold while round 5 is computing.
    applyStimulus(FIPS_KEY, 4, 99, 0);
    waitUntil(lastBase + 4 * PIPE_LAT + 1);
    hold_i  = 1'b1;
    abort_i = 1'b1;
    @(negedge clk);
    hold_i  = 1'b0;
    abort_i = 1'b0;
    checkIdle("afterAbort");
    checkOutput("abortDone", 128'(done_o), 128'h0);
    checkOutput("abortValid", 128'(rk_valid_o), 128'h0);
    applyStimulus(FIPS_KEY, NUM_ROUNDS, 99, 0);
    waitDrain(40);

    // Asynchronous reset in the middle of an expansion.
    applyStimulus(FIPS_KEY, NUM_ROUNDS, 99, 0);
    waitUntil(lastBase + 5);
    nrst = 1'b0;
    #1 checkResetState("midReset");
    expQ.delete();
    @(negedge clk);
    nrst = 1'b1;

    // start_i held high: ignored in the done cycle, taken on the following idle cycle.
    @(negedge clk);
    lastBase = cyc + 1;
    pushExpansion(lastBase, NUM_ROUNDS, 99, 0);
    pushExpansion(lastBase + NUM_ROUNDS * PIPE_LAT + 2, NUM_ROUNDS, 99, 0);
    start_i = 1'b1;
    key_i   = FIPS_KEY;
    waitUntil(lastBase + NUM_ROUNDS * PIPE_LAT);
    checkOutput("readyInDone", 128'(ready_o), 128'h0);
    @(negedge clk);
    checkOutput("readyAfterDone", 128'(ready_o), 128'h1);
    @(negedge clk);
    start_i = 1'b0;
    waitDrain(40);
    checkIdle("final");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
